// File: rtl/axi_lite_cmd_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_lite_cmd_arbiter_if
//
// Purpose: bundles the requester command/response signals and the user port of
// the shared axi_master into one interface so the arbiter and its environment
// connect through a single port.
//
// Parameter:
//   NUM_REQ          number of requesters (2..8)
//
// Signals:
//   req_valid/req_write/req_addr/req_wdata   requester commands (packed 32b)
//   req_ready/rsp_valid/rsp_rdata/rsp_err    accept and completion back
//   start_write/start_read/write_data/write_address_M/read_address
//                                            command strobes to the master
//   read_data/write_done/read_done           completion status from master
//
// Modports:
//   master  the arbiter's view (drives the requester responses and master cmds)
//   slave   the environment's view (requesters plus the axi_master user port)
// -----------------------------------------------------------------------------
interface axi_lite_cmd_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  start_write;
    logic                  start_read;
    logic [31:0]           write_data;
    logic [31:0]           write_address_M;
    logic [31:0]           read_address;
    logic [31:0]           read_data;
    logic                  write_done;
    logic                  read_done;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  read_data, write_done, read_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output start_write, start_read, write_data, write_address_M, read_address
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output read_data, write_done, read_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  start_write, start_read, write_data, write_address_M, read_address
    );
endinterface

// File: rtl/axi_lite_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_cmd_arbiter
//
// Purpose: round-robin arbiter sharing one axi_master AXI4-Lite initiator
// between NUM_REQ requesters. One command is in flight at a time: the winner
// is latched, the master is started with a one-cycle strobe, the matching done
// flag is awaited, and a one-cycle response (with read data) is returned to
// the granted requester.
//
// Parameters:
//   NUM_REQ          number of requesters (2..8)
//   TIMEOUT_CYCLES   WAIT-state cycle limit, used only with AXI_ARB_TIMEOUT_EN
//
// Ports:
//   clk   single rising-edge clock
//   rst   synchronous active-high reset
//   bus   axi_lite_cmd_arbiter_if.master (requester side and master user port)
//
// Optional feature macro:
//   AXI_ARB_TIMEOUT_EN  when defined, a command whose done flag does not arrive
//                       within TIMEOUT_CYCLES WAIT cycles completes with
//                       rsp_err=1 and rsp_rdata=0; otherwise rsp_err is 0.
// -----------------------------------------------------------------------------
module axi_lite_cmd_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_cmd_arbiter_if.master bus
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        lastGrant_q;
    logic                 dirWrite_q;
    logic [NUM_REQ-1:0]   reqReady_q;
    logic [NUM_REQ-1:0]   rspValid_q;
    logic [31:0]          rspRdata_q;
    logic                 startWrite_q;
    logic                 startRead_q;
    logic [31:0]          writeData_q;
    logic [31:0]          writeAddr_q;
    logic [31:0]          readAddr_q;

    logic [GW-1:0]        winner_d;
    logic                 anyValid_d;
    logic                 doneSeen_d;

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]        timer_q;
    logic                 rspErr_q;
`endif

    // Round-robin search starting one past the last grant. Walking the
    // offsets 1..NUM_REQ and keeping the first hit gives the closest
    // requester after last_grant, and the modulo handles non-power-of-two
    // requester counts by wrapping NUM_REQ-1 back to 0.
    always_comb begin
        winner_d   = '0;
        anyValid_d = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!anyValid_d && bus.req_valid[(int'(lastGrant_q) + i) % NUM_REQ]) begin
                anyValid_d = 1'b1;
                winner_d   = GW'((int'(lastGrant_q) + i) % NUM_REQ);
            end
        end
    end

    // Only the done flag of the latched direction may complete a command;
    // the opposite flag can legitimately still be high from an older command.
    always_comb begin
        doneSeen_d = dirWrite_q ? bus.write_done : bus.read_done;
    end

    // Main FSM. Every output is a register loaded on the transition into the
    // state where it must be visible, so strobes appear exactly in ISSUE/RESP
    // and are cleared by the per-cycle defaults. Address/data registers are
    // loaded straight from the winner in IDLE and then hold between commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            lastGrant_q  <= GW'(NUM_REQ - 1);
            dirWrite_q   <= 1'b0;
            reqReady_q   <= '0;
            rspValid_q   <= '0;
            rspRdata_q   <= '0;
            startWrite_q <= 1'b0;
            startRead_q  <= 1'b0;
            writeData_q  <= '0;
            writeAddr_q  <= '0;
            readAddr_q   <= '0;
`ifdef AXI_ARB_TIMEOUT_EN
            timer_q      <= '0;
            rspErr_q     <= 1'b0;
`endif
        end else begin
            reqReady_q   <= '0;
            rspValid_q   <= '0;
            startWrite_q <= 1'b0;
            startRead_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (anyValid_d) begin
                        grant_q    <= winner_d;
                        dirWrite_q <= bus.req_write[winner_d];
                        reqReady_q <= ONE_HOT_0 << winner_d;
                        if (bus.req_write[winner_d]) begin
                            startWrite_q <= 1'b1;
                            writeAddr_q  <= bus.req_addr[int'(winner_d)*32 +: 32];
                            writeData_q  <= bus.req_wdata[int'(winner_d)*32 +: 32];
                        end else begin
                            startRead_q  <= 1'b1;
                            readAddr_q   <= bus.req_addr[int'(winner_d)*32 +: 32];
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    lastGrant_q <= grant_q;
`ifdef AXI_ARB_TIMEOUT_EN
                    timer_q     <= '0;
`endif
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (doneSeen_d) begin
                        rspValid_q <= ONE_HOT_0 << grant_q;
                        rspRdata_q <= dirWrite_q ? 32'h0 : bus.read_data;
`ifdef AXI_ARB_TIMEOUT_EN
                        rspErr_q   <= 1'b0;
`endif
                        state_q    <= RESP;
                    end
`ifdef AXI_ARB_TIMEOUT_EN
                    else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        rspValid_q <= ONE_HOT_0 << grant_q;
                        rspRdata_q <= 32'h0;
                        rspErr_q   <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        timer_q    <= timer_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rspRdata_q <= 32'h0;
`ifdef AXI_ARB_TIMEOUT_EN
                    rspErr_q   <= 1'b0;
`endif
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready       = reqReady_q;
    assign bus.rsp_valid       = rspValid_q;
    assign bus.rsp_rdata       = rspRdata_q;
    assign bus.start_write     = startWrite_q;
    assign bus.start_read      = startRead_q;
    assign bus.write_data      = writeData_q;
    assign bus.write_address_M = writeAddr_q;
    assign bus.read_address    = readAddr_q;
`ifdef AXI_ARB_TIMEOUT_EN
    assign bus.rsp_err         = rspErr_q;
`else
    assign bus.rsp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_cmd_arbiter
//
// Directed vectors drive requester commands and a small behavioural model of
// the axi_master user port. Each issued command pushes its expected grant and
// expected response into queues; independent monitors pop and compare them
// whenever the DUT presents a start strobe or a response pulse.
// -----------------------------------------------------------------------------
module tb_axi_lite_cmd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TO      = 16;

    typedef struct {
        int          idx;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        bit          err;
        bit          hang;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;

    int vecCount  = 0;
    int missCount = 0;
    int cyc       = 0;

    grant_t expGrant[$];
    rsp_t   expRsp[$];
    grant_t gCur;
    rsp_t   rCur;

    bit outstanding = 1'b0;
    bit prevStart   = 1'b0;
    int startCycle  = 0;

    int          slaveDelay  = 0;
    bit          slaveHang   = 1'b0;
    logic [31:0] slaveRdata  = '0;
    int          slaveCnt    = 0;
    bit          slaveActive = 1'b0;
    bit          slaveIsWrite = 1'b0;
    int          doneCycle   = 0;

    axi_lite_cmd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    axi_lite_cmd_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock plus a cycle counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports miscompares.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Every DUT output must read zero while idle straight out of reset.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"},   32'(bus.req_ready),   32'h0);
        checkOutput({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'h0);
        checkOutput({tag, "_rsp_rdata"},   bus.rsp_rdata,        32'h0);
        checkOutput({tag, "_rsp_err"},     32'(bus.rsp_err),     32'h0);
        checkOutput({tag, "_start_write"}, 32'(bus.start_write), 32'h0);
        checkOutput({tag, "_start_read"},  32'(bus.start_read),  32'h0);
        checkOutput({tag, "_write_data"},  bus.write_data,       32'h0);
        checkOutput({tag, "_write_addr"},  bus.write_address_M,  32'h0);
        checkOutput({tag, "_read_addr"},   bus.read_address,     32'h0);
    endtask

    // Behavioural axi_master user port: clears the matching done flag on a
    // start strobe, then raises it after slaveDelay further cycles (never when
    // slaveHang is set). Done flags are levels and stay high until the next
    // start of the same direction, which is what makes stale flags possible.
    always @(negedge clk) begin
        if (rst) begin
            slaveActive    = 1'b0;
            bus.write_done = 1'b0;
            bus.read_done  = 1'b0;
            bus.read_data  = 32'h0;
        end else if (bus.start_write || bus.start_read) begin
            slaveActive  = 1'b1;
            slaveIsWrite = bus.start_write;
            slaveCnt     = slaveDelay;
            if (bus.start_write) bus.write_done = 1'b0;
            else                 bus.read_done  = 1'b0;
        end else if (slaveActive && !slaveHang) begin
            if (slaveCnt == 0) begin
                slaveActive = 1'b0;
                doneCycle   = cyc;
                if (slaveIsWrite) begin
                    bus.read_data  = 32'hBAD0_BAD0;
                    bus.write_done = 1'b1;
                end else begin
                    bus.read_data = slaveRdata;
                    bus.read_done = 1'b1;
                end
            end else begin
                slaveCnt--;
            end
        end
    end

    // Grant monitor: each start strobe must match the next expected grant,
    // be a single-cycle pulse, and never overlap an outstanding command.
    always @(negedge clk) begin
        if (rst) begin
            prevStart   = 1'b0;
            outstanding = 1'b0;
        end else begin
            if (bus.start_write || bus.start_read) begin
                checkOutput("startPulseWidth", 32'(prevStart), 32'h0);
                checkOutput("oneOutstanding", 32'(outstanding), 32'h0);
                if (expGrant.size() == 0) begin
                    checkOutput("unexpectedStart", 32'(expGrant.size()), 32'h1);
                end else begin
                    gCur = expGrant.pop_front();
                    checkOutput("grantReady", 32'(bus.req_ready), 32'd1 << gCur.idx);
                    checkOutput("startWrite", 32'(bus.start_write), 32'(gCur.write));
                    checkOutput("startRead",  32'(bus.start_read),  32'(!gCur.write));
                    if (gCur.write) begin
                        checkOutput("writeAddr", bus.write_address_M, gCur.addr);
                        checkOutput("writeData", bus.write_data,      gCur.wdata);
                    end else begin
                        checkOutput("readAddr",  bus.read_address,    gCur.addr);
                    end
                end
                outstanding = 1'b1;
                startCycle  = cyc;
            end else if (bus.req_ready != '0) begin
                checkOutput("readyWithoutStart", 32'(bus.req_ready), 32'h0);
            end
            prevStart = bus.start_write || bus.start_read;
        end
    end

    // Response monitor: each response pulse is compared against the next
    // expected response, including its latency from done (or from start when
    // the command is expected to time out).
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid != '0) begin
            if (expRsp.size() == 0) begin
                checkOutput("unexpectedRsp", 32'(bus.rsp_valid), 32'h0);
            end else begin
                rCur = expRsp.pop_front();
                checkOutput("rspValid", 32'(bus.rsp_valid), 32'd1 << rCur.idx);
                checkOutput("rspRdata", bus.rsp_rdata, rCur.rdata);
                checkOutput("rspErr",   32'(bus.rsp_err), 32'(rCur.err));
                if (rCur.hang)
                    checkOutput("timeoutLatency", 32'(cyc - startCycle), 32'd17);
                else
                    checkOutput("doneLatency", 32'(cyc - doneCycle), 32'd1);
            end
            outstanding = 1'b0;
        end
    end

    // Wait (bounded) for the accept pulse of requester idx.
    task automatic waitReady(input int idx);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) got = 1'b1;
        end
        checkOutput($sformatf("readyTimeout%0d", idx), 32'(got), 32'h1);
    endtask

    // Wait (bounded) until every expected grant and response has been seen.
    task automatic waitIdle();
        for (int i = 0; i < 100 && (expRsp.size() != 0 || expGrant.size() != 0); i++)
            @(negedge clk);
        checkOutput("rspTimeout", 32'(expRsp.size() + expGrant.size()), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    // Post one command, record its expectations and wait for the accept.
    task automatic issueOnly(input int idx, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int delay, input bit hang);
        @(negedge clk);
        slaveDelay = delay;
        slaveHang  = hang;
        slaveRdata = rdata;
        bus.req_write[idx]          = wr;
        bus.req_addr[idx*32 +: 32]  = addr;
        bus.req_wdata[idx*32 +: 32] = wdata;
        bus.req_valid[idx]          = 1'b1;
        expGrant.push_back('{idx, wr, addr, wdata});
        expRsp.push_back('{idx, (hang || wr) ? 32'h0 : rdata, hang, hang});
        waitReady(idx);
        bus.req_valid[idx] = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int delay, input bit hang);
        issueOnly(idx, wr, addr, wdata, rdata, delay, hang);
        waitIdle();
    endtask

    // Directed sequence.
    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // Basic write from requester 0, then read from requester 1.
        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        applyStimulus(1, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

        // Both done flags are now stale-high; new commands must wait for
        // their own done, and the opposite flag must be ignored.
        applyStimulus(0, 1'b1, 32'h30, 32'h55AA_55AA, 32'h0, 3, 1'b0);
        applyStimulus(1, 1'b0, 32'h40, 32'h0, 32'h0BAD_F00D, 3, 1'b0);

        // Both requesters continuously valid: strict 0,1,0,1,0,1 rotation.
        @(negedge clk);
        slaveDelay = 1;
        slaveHang  = 1'b0;
        slaveRdata = 32'h1234_5678;
        bus.req_write[0]      = 1'b1;
        bus.req_addr[31:0]    = 32'h200;
        bus.req_wdata[31:0]   = 32'hA5A5_0000;
        bus.req_write[1]      = 1'b0;
        bus.req_addr[63:32]   = 32'h300;
        bus.req_wdata[63:32]  = 32'h0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                expGrant.push_back('{0, 1'b1, 32'h200, 32'hA5A5_0000});
                expRsp.push_back('{0, 32'h0, 1'b0, 1'b0});
            end else begin
                expGrant.push_back('{1, 1'b0, 32'h300, 32'h0});
                expRsp.push_back('{1, 32'h1234_5678, 1'b0, 1'b0});
            end
        end
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            waitReady(k % 2);
            if (k >= 4) bus.req_valid[k % 2] = 1'b0;
        end
        waitIdle();

        // Reset during WAIT: no response, and last_grant returns to NUM_REQ-1
        // so requester 0 wins again even though it was granted last.
        issueOnly(0, 1'b1, 32'h500, 32'h7777_7777, 32'h0, 0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expRsp.delete();
        expGrant.delete();
        checkResetOutputs("midReset");
        rst = 1'b0;
        @(negedge clk);
        slaveDelay = 0;
        slaveHang  = 1'b0;
        slaveRdata = 32'h0000_0099;
        bus.req_write[0]     = 1'b1;
        bus.req_addr[31:0]   = 32'h600;
        bus.req_wdata[31:0]  = 32'h0000_0066;
        bus.req_write[1]     = 1'b0;
        bus.req_addr[63:32]  = 32'h700;
        expGrant.push_back('{0, 1'b1, 32'h600, 32'h0000_0066});
        expGrant.push_back('{1, 1'b0, 32'h700, 32'h0});
        expRsp.push_back('{0, 32'h0, 1'b0, 1'b0});
        expRsp.push_back('{1, 32'h0000_0099, 1'b0, 1'b0});
        bus.req_valid = 2'b11;
        waitReady(0);
        bus.req_valid[0] = 1'b0;
        waitReady(1);
        bus.req_valid[1] = 1'b0;
        waitIdle();

`ifdef AXI_ARB_TIMEOUT_EN
        // Slave never answers: error response 17 cycles after start, then
        // the following request is serviced normally.
        applyStimulus(0, 1'b0, 32'h800, 32'h0, 32'hFFFF_FFFF, 0, 1'b1);
        applyStimulus(1, 1'b1, 32'h900, 32'h0000_0012, 32'h0, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_arbiter.md
# axi_lite_cmd_arbiter

Round-robin command arbiter that shares one `axi_master` AXI4-Lite initiator between `NUM_REQ` independent requesters. Each requester posts a single read or write command. The arbiter grants one command at a time, pulses the master's `start_write`/`start_read`, and waits for the matching `write_done`/`read_done`. It then returns a one-cycle response, with read data, to the granted requester. The block sits between the system-side command sources and the master's user port; the master's AXI channels are untouched.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 256: WAIT-state cycle limit. Used only with `AXI_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester command pending. Held until `req_ready`.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*32  packed addresses; requester i uses bits [32i+31:32i].
- `req_wdata`  in  NUM_REQ*32  packed write data, same packing.
- `req_ready`  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `rsp_rdata`  out  32  read data, shared. Valid while any `rsp_valid` bit is high.
- `rsp_err`  out  1  timeout flag, qualified by `rsp_valid`.
- `start_write`  out  1  to master.
- `start_read`  out  1  to master.
- `write_data`  out  32  to master.
- `write_address_M`  out  32  to master.
- `read_address`  out  32  to master.
- `read_data`  in  32  from master.
- `write_done`  in  1  from master. Level; the master clears it one edge after `start_write`.
- `read_done`  in  1  from master. Level; the master clears it one edge after `start_read`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, any `req_valid` set:
  - Pick the winner by round-robin, searching from `last_grant+1` and wrapping modulo `NUM_REQ`.
  - Latch the winner's index, direction, address and wdata.
  - Go to ISSUE.
- ISSUE (exactly one cycle):
  - `req_ready[g]=1`.
  - Exactly one of `start_write`/`start_read` = 1.
  - Address/data outputs driven from the latched values.
  - `last_grant <= g`.
  - Go to WAIT.
- WAIT:
  - Sample only the done flag matching the latched direction.
  - Flag high → capture `read_data` (reads only) and go to RESP.
  - The first WAIT cycle already sees the flag cleared by the master, so stale done flags are never consumed.
- RESP (one cycle): `rsp_valid[g]=1`, `rsp_rdata` = captured data (0 for writes), `rsp_err` per timeout. Go to IDLE.
- Only one command is outstanding at a time; requests arriving during ISSUE/WAIT/RESP wait.
- `req_valid` dropped before `req_ready`: the latched command still executes. This is a protocol violation; the requester must not do it.
- All outputs are registered.
- `start_*`, `req_ready`, `rsp_valid` are never high outside their state.
- `write_address_M`, `read_address`, `write_data` hold their last value between commands.

## Timing
- Reset values:
  - State IDLE; `last_grant = NUM_REQ-1`, so requester 0 wins first after reset.
  - All outputs 0, including address/data buses.
  - Timeout counter 0.
- Reset in any state: return to IDLE next edge with no response. The master is reset by the system, not by this block.
- Latency: `req_valid` seen at cycle T → `req_ready`/`start_*` at T+1.
- Done seen at cycle W → `rsp_valid` at W+1.
- Back-to-back: next `start_*` no earlier than W+3. Minimum of 4 cycles per command with an instantaneous slave.
- Simultaneous requests: strict rotation. Two requesters permanently valid alternate grants; no starvation.
- `NUM_REQ` not a power of two: pointer wraps from `NUM_REQ-1` to 0.
- Done flag of the opposite direction during WAIT: ignored.

## Configuration
- `AXI_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - Reaching `TIMEOUT_CYCLES` without done → go to RESP with `rsp_err=1` and `rsp_rdata=0`.
  - The counter clears on entry to WAIT.
- Not defined: no counter; WAIT holds until done; `rsp_err` is tied to 0.

## Test plan
- Reset, then requester 0 write addr 0x10 data 0xDEADBEEF → `start_write` one cycle with matching `write_address_M`/`write_data`; `rsp_valid[0]` one cycle after `write_done`; `rsp_err=0`.
- Requester 1 read addr 0x20, slave returns 0xCAFEF00D → `start_read` one cycle, `rsp_rdata=0xCAFEF00D` with `rsp_valid[1]`.
- Both requesters continuously valid for 6 commands → grant order 0,1,0,1,0,1; never two `start_*` without an intervening response.
- `write_done` still high from a previous write when a new write issues → no early response; `rsp_valid` only after the new done.
- `rst` asserted during WAIT → IDLE next edge, no `rsp_valid`; `last_grant` back to `NUM_REQ-1`.
- `AXI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`, slave never responds → `rsp_valid` with `rsp_err=1` 17 cycles after `start_*`, then the next request is serviced.
